// File: rtl/sharpen_unsharp_axis_if.sv
// Valid/ready stream bundle shared by the sharpening block's input and output sides.
// On the input side tdata packs {original pixel, 3x3 window}.
interface sharpen_unsharp_axis_if #(
   parameter int DATA_W = 8
);
   logic              tvalid;
   logic              tready;
   logic              tuser;
   logic              tlast;
   logic [DATA_W-1:0] tdata;

   modport master (output tvalid, tuser, tlast, tdata, input tready);
   modport slave  (input tvalid, tuser, tlast, tdata, output tready);
endinterface

// File: rtl/sharpen_unsharp_axis.sv
// Unsharp-mask sharpening: Laplacian detail (cross or 8-neighbour), coring, fixed-point gain,
// per-channel add with clamp. Three-stage valid/ready pipeline, config latched on accepted SOF.
module sharpen_unsharp_axis #(
   parameter int PXL_D_WIDTH = 8,
   parameter int NUM_CH      = 3,
   parameter int GAIN_W      = 6,
   parameter int GAIN_FRAC   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   sharpen_unsharp_axis_if.slave     s_axis,
   sharpen_unsharp_axis_if.master    m_axis,
   input  logic                      cfg_mode,
   input  logic [GAIN_W-1:0]         cfg_gain,
   input  logic [PXL_D_WIDTH-1:0]    cfg_core_thr,
   input  logic                      cfg_bypass
);
   localparam int W      = PXL_D_WIDTH;
   localparam int LAP_W  = W + 5;
   localparam int PROD_W = LAP_W + GAIN_W + 1;
   localparam int DET_W  = W + 2;
   localparam int SUM_W  = W + 3;
   localparam int WIN_W  = 9 * W;
   localparam int ORG_W  = NUM_CH * W;

   localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1 << (GAIN_FRAC - 1));
   localparam logic signed [PROD_W-1:0] DET_MAX  = PROD_W'((1 << (W + 1)) - 1);
   localparam logic signed [PROD_W-1:0] DET_MIN  = PROD_W'(-(1 << (W + 1)));
   localparam logic signed [SUM_W-1:0]  PIX_MAX  = SUM_W'((1 << W) - 1);

   // Round half up (floor after adding half), then saturate to the detail range.
   function automatic logic signed [DET_W-1:0] f_round_sat(input logic signed [PROD_W-1:0] prod);
      logic signed [PROD_W-1:0] rnd;
      rnd = (prod + RND_HALF) >>> GAIN_FRAC;
      if (rnd > DET_MAX) return DET_W'(DET_MAX);
      if (rnd < DET_MIN) return DET_W'(DET_MIN);
      return rnd[DET_W-1:0];
   endfunction

   function automatic logic [W-1:0] f_add_clamp(input logic [W-1:0] org,
                                                input logic signed [DET_W-1:0] det);
      logic signed [SUM_W-1:0] sum;
      sum = SUM_W'($signed({1'b0, org})) + SUM_W'(det);
      if (sum[SUM_W-1]) return '0;
      if (sum > PIX_MAX) return PIX_MAX[W-1:0];
      return sum[W-1:0];
   endfunction

   logic                     w_en_p1, w_en_p2, w_en_p3, w_sof_acc;
   logic                     w_mode, w_bypass;
   logic [GAIN_W-1:0]        w_gain;
   logic [W-1:0]             w_thr;
   logic [LAP_W-1:0]         w_nbr_sum, w_centre;
   logic signed [LAP_W-1:0]  w_lap;
   logic [LAP_W-1:0]         w_abs_p1;
   logic signed [PROD_W-1:0] w_prod_p1;
   logic signed [DET_W-1:0]  w_detail_p1;
   logic [ORG_W-1:0]         w_pix_p2;

   logic                     r_cfg_mode, r_cfg_bypass;
   logic [GAIN_W-1:0]        r_cfg_gain;
   logic [W-1:0]             r_cfg_thr;

   logic                     r_vld_p1, r_user_p1, r_last_p1, r_bypass_p1;
   logic signed [LAP_W-1:0]  r_lap_p1;
   logic [ORG_W-1:0]         r_org_p1;
   logic [GAIN_W-1:0]        r_gain_p1;
   logic [W-1:0]             r_thr_p1;

   logic                     r_vld_p2, r_user_p2, r_last_p2, r_bypass_p2;
   logic signed [DET_W-1:0]  r_detail_p2;
   logic [ORG_W-1:0]         r_org_p2;

   logic                     r_vld_p3, r_user_p3, r_last_p3;
   logic [ORG_W-1:0]         r_data_p3;

   assign w_en_p3 = !r_vld_p3 | m_axis.tready;
   assign w_en_p2 = !r_vld_p2 | w_en_p3;
   assign w_en_p1 = !r_vld_p1 | w_en_p2;
   assign s_axis.tready = w_en_p1;

   // The SOF beat itself already sees the incoming configuration.
   assign w_sof_acc = s_axis.tvalid & s_axis.tuser & w_en_p1;
   assign w_mode    = w_sof_acc ? cfg_mode     : r_cfg_mode;
   assign w_gain    = w_sof_acc ? cfg_gain     : r_cfg_gain;
   assign w_thr     = w_sof_acc ? cfg_core_thr : r_cfg_thr;
   assign w_bypass  = w_sof_acc ? cfg_bypass   : r_cfg_bypass;

   // ---- S1: Laplacian ----
   always_comb begin
      w_nbr_sum = '0;
      for (int i = 0; i < 9; i++) begin
         if (i != 4 && (w_mode || (i % 2 == 1)))
            w_nbr_sum = w_nbr_sum + LAP_W'(s_axis.tdata[i*W +: W]);
      end
      w_centre = LAP_W'(s_axis.tdata[4*W +: W]);
      w_lap    = (w_mode ? (w_centre << 3) : (w_centre << 2)) - w_nbr_sum;
   end

   // ---- S2: coring and gain ----
   assign w_abs_p1    = r_lap_p1[LAP_W-1] ? -r_lap_p1 : r_lap_p1;
   assign w_prod_p1   = PROD_W'(r_lap_p1) * PROD_W'($signed({1'b0, r_gain_p1}));
   assign w_detail_p1 = (w_abs_p1 < LAP_W'(r_thr_p1)) ? '0 : f_round_sat(w_prod_p1);

   // ---- S3: add detail and clamp per channel ----
   always_comb begin
      w_pix_p2 = r_org_p2;
      if (!r_bypass_p2) begin
         for (int k = 0; k < NUM_CH; k++)
            w_pix_p2[k*W +: W] = f_add_clamp(r_org_p2[k*W +: W], r_detail_p2);
      end
   end

   always_ff @(posedge clk) begin
      if (w_en_p1) begin
         r_lap_p1    <= w_lap;
         r_org_p1    <= s_axis.tdata[WIN_W +: ORG_W];
         r_gain_p1   <= w_gain;
         r_thr_p1    <= w_thr;
         r_bypass_p1 <= w_bypass;
      end
      if (w_en_p2) begin
         r_detail_p2 <= w_detail_p1;
         r_org_p2    <= r_org_p1;
         r_bypass_p2 <= r_bypass_p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg_mode   <= 1'b0;
         r_cfg_gain   <= '0;
         r_cfg_thr    <= '0;
         r_cfg_bypass <= 1'b1;
         r_vld_p1 <= 1'b0; r_user_p1 <= 1'b0; r_last_p1 <= 1'b0;
         r_vld_p2 <= 1'b0; r_user_p2 <= 1'b0; r_last_p2 <= 1'b0;
         r_vld_p3 <= 1'b0; r_user_p3 <= 1'b0; r_last_p3 <= 1'b0;
         r_data_p3 <= '0;
      end else begin
         if (w_sof_acc) begin
            r_cfg_mode   <= cfg_mode;
            r_cfg_gain   <= cfg_gain;
            r_cfg_thr    <= cfg_core_thr;
            r_cfg_bypass <= cfg_bypass;
         end
         if (w_en_p1) begin
            r_vld_p1  <= s_axis.tvalid;
            r_user_p1 <= s_axis.tuser;
            r_last_p1 <= s_axis.tlast;
         end
         if (w_en_p2) begin
            r_vld_p2  <= r_vld_p1;
            r_user_p2 <= r_user_p1;
            r_last_p2 <= r_last_p1;
         end
         if (w_en_p3) begin
            r_vld_p3  <= r_vld_p2;
            r_user_p3 <= r_user_p2;
            r_last_p3 <= r_last_p2;
            r_data_p3 <= w_pix_p2;
         end
      end
   end

   assign m_axis.tvalid = r_vld_p3;
   assign m_axis.tuser  = r_user_p3;
   assign m_axis.tlast  = r_last_p3;
   assign m_axis.tdata  = r_data_p3;
endmodule

// File: tb/tb_sharpen_unsharp_axis.sv
// Directed bench for sharpen_unsharp_axis: vector table plus stall, config and reset sequences.
module tb_sharpen_unsharp_axis;
   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_mode, cfg_bypass;
   logic [5:0] cfg_gain;
   logic [7:0] cfg_core_thr;
   int         n_tests = 0;
   int         n_fail  = 0;

   typedef struct {
      string       name;
      bit          mode;
      logic [5:0]  gain;
      logic [7:0]  thr;
      bit          byp;
      bit          sof;
      bit          last;
      logic [71:0] win;
      logic [23:0] org;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[14];

   sharpen_unsharp_axis_if #(.DATA_W(96)) s_if ();
   sharpen_unsharp_axis_if #(.DATA_W(24)) m_if ();

   sharpen_unsharp_axis #(
      .PXL_D_WIDTH(8), .NUM_CH(3), .GAIN_W(6), .GAIN_FRAC(2)
   ) dut (
      .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
      .cfg_mode(cfg_mode), .cfg_gain(cfg_gain), .cfg_core_thr(cfg_core_thr),
      .cfg_bypass(cfg_bypass)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   // Centre c, tap 1 = x1, taps 3/5/7 = x, diagonals = d.
   function automatic logic [71:0] mkwin(input logic [7:0] c, input logic [7:0] x1,
                                         input logic [7:0] x, input logic [7:0] d);
      logic [71:0] w;
      w = '0;
      w[4*8 +: 8] = c;
      w[1*8 +: 8] = x1;
      w[3*8 +: 8] = x;  w[5*8 +: 8] = x;  w[7*8 +: 8] = x;
      w[0*8 +: 8] = d;  w[2*8 +: 8] = d;  w[6*8 +: 8] = d;  w[8*8 +: 8] = d;
      return w;
   endfunction

   function automatic vec_t mkvec(input string nm, input bit mode, input logic [5:0] gain,
                                  input logic [7:0] thr, input bit byp, input bit sof,
                                  input bit last, input logic [71:0] win,
                                  input logic [23:0] org, input logic [23:0] exp);
      vec_t v;
      v.name = nm; v.mode = mode; v.gain = gain; v.thr = thr; v.byp = byp;
      v.sof = sof; v.last = last; v.win = win; v.org = org; v.exp = exp;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      int lat, w;
      bit got;
      @(negedge clk);
      s_if.tdata  = {v.org, v.win};
      s_if.tuser  = v.sof;
      s_if.tlast  = v.last;
      s_if.tvalid = 1'b1;
      cfg_mode = v.mode; cfg_gain = v.gain; cfg_core_thr = v.thr; cfg_bypass = v.byp;
      #1;
      w = 0;
      while (!s_if.tready && w < 20) begin
         @(negedge clk); #1; w++;
      end
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
      lat = 1; got = 1'b0;
      while (!got && lat <= 10) begin
         @(negedge clk);
         if (m_if.tvalid) got = 1'b1;
         else lat++;
      end
      chk({v.name, " latency"}, 64'(lat), 64'(3));
      chk({v.name, " data"},    64'(m_if.tdata), 64'(v.exp));
      chk({v.name, " tuser"},   64'(m_if.tuser), 64'(v.sof));
      chk({v.name, " tlast"},   64'(m_if.tlast), 64'(v.last));
      @(posedge clk);
   endtask

   initial begin
      vecs[0]  = mkvec("flat",      0, 4,  0,  0, 1, 0, mkwin(100, 100, 100, 100),
                       {8'd100, 8'd100, 8'd100}, {8'd100, 8'd100, 8'd100});
      vecs[1]  = mkvec("cross_p80", 0, 4,  0,  0, 1, 0, mkwin(120, 100, 100, 37),
                       {8'd200, 8'd150, 8'd10},  {8'd255, 8'd230, 8'd90});
      vecs[2]  = mkvec("cross_m80", 0, 4,  0,  0, 1, 1, mkwin(80, 100, 100, 37),
                       {8'd50, 8'd150, 8'd255},  {8'd0, 8'd70, 8'd175});
      vecs[3]  = mkvec("nbr8_160",  1, 4,  0,  0, 1, 0, mkwin(120, 100, 100, 100),
                       {8'd10, 8'd20, 8'd30},    {8'd170, 8'd180, 8'd190});
      vecs[4]  = mkvec("g2_lap3",   0, 2,  0,  0, 1, 0, mkwin(100, 100, 99, 0),
                       {8'd50, 8'd60, 8'd70},    {8'd52, 8'd62, 8'd72});
      vecs[5]  = mkvec("g2_lapm3",  0, 2,  0,  0, 1, 0, mkwin(100, 100, 101, 0),
                       {8'd0, 8'd60, 8'd70},     {8'd0, 8'd59, 8'd69});
      vecs[6]  = mkvec("core_lap9", 0, 2,  10, 0, 1, 0, mkwin(100, 100, 97, 0),
                       {8'd50, 8'd60, 8'd70},    {8'd50, 8'd60, 8'd70});
      vecs[7]  = mkvec("core_lap10",0, 2,  10, 0, 1, 0, mkwin(100, 99, 97, 0),
                       {8'd50, 8'd60, 8'd70},    {8'd55, 8'd65, 8'd75});
      vecs[8]  = mkvec("core_lapm10",0, 2, 10, 0, 1, 0, mkwin(100, 101, 103, 0),
                       {8'd50, 8'd60, 8'd70},    {8'd45, 8'd55, 8'd65});
      vecs[9]  = mkvec("g1_frac",   0, 1,  0,  0, 1, 0, mkwin(120, 100, 100, 0),
                       {8'd10, 8'd20, 8'd30},    {8'd30, 8'd40, 8'd50});
      vecs[10] = mkvec("bypass",    0, 63, 0,  1, 1, 1, mkwin(255, 0, 0, 0),
                       {8'd1, 8'd2, 8'd3},       {8'd1, 8'd2, 8'd3});
      vecs[11] = mkvec("sat_pos",   0, 63, 0,  0, 1, 0, mkwin(110, 100, 100, 0),
                       {8'd0, 8'd100, 8'd255},   {8'd255, 8'd255, 8'd255});
      vecs[12] = mkvec("sat_neg",   0, 63, 0,  0, 1, 0, mkwin(90, 100, 100, 0),
                       {8'd255, 8'd200, 8'd0},   {8'd0, 8'd0, 8'd0});
      vecs[13] = mkvec("nbr8_diag", 1, 4,  0,  0, 1, 0, mkwin(100, 100, 100, 90),
                       {8'd10, 8'd100, 8'd200},  {8'd50, 8'd140, 8'd240});

      rst = 1'b1;
      s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
      m_if.tready = 1'b1;
      cfg_mode = 1'b0; cfg_gain = 6'd0; cfg_core_thr = 8'd0; cfg_bypass = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset tvalid", 64'(m_if.tvalid), 64'(0));
      chk("reset tdata",  64'(m_if.tdata),  64'(0));
      chk("reset tuser",  64'(m_if.tuser),  64'(0));
      chk("reset tlast",  64'(m_if.tlast),  64'(0));
      chk("reset s_tready", 64'(s_if.tready), 64'(1));
      rst = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);

      // Gain change without SOF is ignored; the next SOF beat picks it up.
      run_vec(mkvec("cfg_g4",     0, 4, 0, 0, 1, 0, mkwin(120, 100, 100, 0),
                    {8'd10, 8'd20, 8'd30}, {8'd90, 8'd100, 8'd110}));
      run_vec(mkvec("cfg_g8_nosof", 0, 8, 0, 0, 0, 0, mkwin(120, 100, 100, 0),
                    {8'd10, 8'd20, 8'd30}, {8'd90, 8'd100, 8'd110}));
      run_vec(mkvec("cfg_g8_sof", 0, 8, 0, 0, 1, 0, mkwin(120, 100, 100, 0),
                    {8'd10, 8'd20, 8'd30}, {8'd170, 8'd180, 8'd190}));

      // Eight-beat stream with downstream stalled for cycles 4..8.
      cfg_mode = 1'b0; cfg_gain = 6'd4; cfg_core_thr = 8'd0; cfg_bypass = 1'b0;
      fork
         begin : driver
            int w;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               s_if.tdata  = {8'(i * 3 + 1), 8'(i * 3 + 2), 8'(i * 3 + 3),
                              mkwin(100, 100, 100, 100)};
               s_if.tuser  = (i == 0);
               s_if.tlast  = (i == 7);
               s_if.tvalid = 1'b1;
               #1;
               w = 0;
               while (!s_if.tready && w < 50) begin
                  @(negedge clk); #1; w++;
               end
               @(posedge clk);
            end
            #1;
            s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
         end
         begin : monitor
            int cyc, got;
            bit prev_stall, saw_block;
            logic [23:0] prev;
            cyc = 0; got = 0; prev_stall = 1'b0; saw_block = 1'b0; prev = '0;
            while (got < 8 && cyc < 100) begin
               @(negedge clk);
               m_if.tready = !(cyc >= 4 && cyc <= 8);
               #1;
               if (!s_if.tready && !m_if.tready) saw_block = 1'b1;
               if (prev_stall) chk("stall hold", 64'(m_if.tdata), 64'(prev));
               if (m_if.tvalid && m_if.tready) begin
                  chk("stall data",  64'(m_if.tdata),
                      64'({8'(got * 3 + 1), 8'(got * 3 + 2), 8'(got * 3 + 3)}));
                  chk("stall tuser", 64'(m_if.tuser), 64'(got == 0));
                  chk("stall tlast", 64'(m_if.tlast), 64'(got == 7));
                  got++;
               end
               prev_stall = m_if.tvalid && !m_if.tready;
               prev = m_if.tdata;
               cyc++;
            end
            chk("stall beat count", 64'(got), 64'(8));
            chk("stall s_tready blocked", 64'(saw_block), 64'(1));
            m_if.tready = 1'b1;
         end
      join
      repeat (2) @(negedge clk);
      chk("stall drained", 64'(m_if.tvalid), 64'(0));

      // Asynchronous reset while an output beat is held.
      m_if.tready = 1'b0;
      @(negedge clk);
      s_if.tdata = {8'd10, 8'd20, 8'd30, mkwin(120, 100, 100, 0)};
      s_if.tuser = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
      cfg_mode = 1'b0; cfg_gain = 6'd4; cfg_core_thr = 8'd0; cfg_bypass = 1'b0;
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst pre tvalid", 64'(m_if.tvalid), 64'(1));
      chk("rst pre data",   64'(m_if.tdata),  64'({8'd90, 8'd100, 8'd110}));
      #2 rst = 1'b1;
      #1;
      chk("rst async tvalid", 64'(m_if.tvalid), 64'(0));
      chk("rst async tdata",  64'(m_if.tdata),  64'(0));
      @(negedge clk);
      rst = 1'b0;
      m_if.tready = 1'b1;
      run_vec(mkvec("post_rst_bypass", 0, 4, 0, 0, 0, 0, mkwin(120, 100, 100, 0),
                    {8'd10, 8'd20, 8'd30}, {8'd10, 8'd20, 8'd30}));
      run_vec(mkvec("post_rst_sof", 0, 4, 0, 0, 1, 0, mkwin(120, 100, 100, 0),
                    {8'd10, 8'd20, 8'd30}, {8'd90, 8'd100, 8'd110}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sharpen_unsharp_axis.md
Name: sharpen_unsharp_axis

Overview:
- Parametrised successor to the fixed-function cross sharpening kernel.
- Computes a Laplacian detail term over a 3x3 luma window, selectable as 4-neighbour cross or full 8-neighbour.
- Applies a programmable fixed-point gain and a coring threshold, then adds the detail to each of NUM_CH original channels with clamping.
- Sits between the line-buffer/window generator and the AXI4-Stream video output.
- Unlike its predecessor, it has full per-stage valid/ready backpressure and frame-synchronous configuration latching.

Parameters:
- PXL_D_WIDTH, 8, bits per channel and per window sample.
- NUM_CH, 3, original-pixel channels; channel k occupies bits [k*PXL_D_WIDTH +: PXL_D_WIDTH].
- GAIN_W, 6, unsigned gain width.
- GAIN_FRAC, 2, fractional bits of gain; unity gain = 1<<GAIN_FRAC; must be >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- win_data  in  9*PXL_D_WIDTH  3x3 window, row-major; tap i (r*3+c) at [i*PXL_D_WIDTH +: PXL_D_WIDTH]; tap 4 is the centre.
- in_org_pixels  in  NUM_CH*PXL_D_WIDTH  original pixel aligned to the centre tap.
- cfg_mode  in  1  0 = cross (taps 1,3,5,7), 1 = 8-neighbour.
- cfg_gain  in  GAIN_W  detail gain, unsigned fixed point.
- cfg_core_thr  in  PXL_D_WIDTH  coring threshold.
- cfg_bypass  in  1  1 = output original pixel.
- m_axis_tdata  out  NUM_CH*PXL_D_WIDTH  output pixel.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  start of frame, delayed.
- m_axis_tlast  out  1  end of line, delayed.

Behaviour:
- Reset: all stage valids 0, so m_axis_tvalid=0. m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0.
- Active configuration resets to mode=0, gain=0, thr=0, bypass=1.
- Reset asserted mid-frame drops all in-flight beats; m_axis_tvalid falls asynchronously.
- Pipeline: 3 stages (S1, S2, S3), each with a valid bit.
  - Stage n loads when its successor can accept or the stage is empty.
  - S3 advances when m_axis_tready=1 or S3 is empty.
  - s_axis_tready = !S1_valid | S1_advances. It is combinational from downstream ready through the chain, with no registered bubble.
- Latency: 3 cycles from accepted beat to m_axis_tvalid when unstalled; throughput 1 beat/cycle.
- No beat is lost or duplicated under any tready pattern. Output payload is held stable while tvalid=1 and tready=0.
- Configuration latching:
  - cfg_* is copied into active registers on the cycle a beat with s_axis_tuser=1 is accepted, and that beat already uses the new values.
  - Config changes without an accepted SOF have no effect.
  - Active config travels with each beat, so a config change never alters beats already in flight.
- S1 computes a signed Laplacian, LAP_W = PXL_D_WIDTH+5 bits:
  - mode 0: 4*c - (t1+t3+t5+t7), range +/-1020 at 8 bits.
  - mode 1: 8*c - (sum of the 8 non-centre taps), range +/-2040.
- S2 coring and gain:
  - If |lap| < thr, detail = 0.
  - Otherwise detail = (lap*gain + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC, which is round-half-up including negatives (-1.5 -> -1).
  - Product width is LAP_W+GAIN_W+1, signed.
  - detail saturates to [-(2^(PXL_D_WIDTH+1)), 2^(PXL_D_WIDTH+1)-1].
- S3 per channel: sum = org_k + detail, clamped to [0, 2^PXL_D_WIDTH-1].
  - In bypass, S3 outputs org unchanged with the same 3-cycle latency.
- tuser and tlast propagate unmodified with the data.

Test Plan:
All cases use PXL_D_WIDTH=8, NUM_CH=3, GAIN_W=6, GAIN_FRAC=2, and ch2..ch0 order.
- Flat window, all taps 100, org {100,100,100}, gain 4, bypass 0, SOF -> {100,100,100} exactly 3 cycles after accept.
- Mode 0, centre 120, cross taps 100, gain 4 -> lap 80; org {200,150,10} -> {255,230,90}. Centre 80 gives lap -80; org {50,150,255} -> {0,70,175}. Mode 1 with centre 120 and all others 100 -> lap 160.
- Gain 2: lap 3 -> detail 2; lap -3 -> detail -1. Coring thr 10: lap 9 -> detail 0; lap 10 -> detail 5.
- Stream of 8 beats, m_axis_tready low for cycles 4-8 -> s_axis_tready low once 3 beats are held; all 8 beats emerge in order, unchanged while stalled; tlast/tuser stay aligned.
- Change cfg_gain 4->8 mid-frame -> no output change until next SOF beat, which uses gain 8. Pulse rst mid-stream -> m_axis_tvalid=0 immediately, bypass active afterwards until SOF.
